debug_snapshot_unit: RTL

- Parametrised debug observation block for the processor top.
- Captures NUM_REGS register-file words plus NUM_MEM data-memory words into a shadow buffer.
- Capture can run continuously, on an armed trigger, or at a fixed decimation interval.
- The testbench or an external debug master reads the frozen image through an addressed read port with 1-cycle latency.
- Replaces the fixed r0..r19/m2/m3 per-cycle copy. The datapath drives the flattened src_data bus.

---
 rtl/debug_snapshot_unit_if.sv | 34 +++
 rtl/debug_snapshot_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_snapshot_unit_if.sv
// -----------------------------------------------------------------------------
// debug_snapshot_unit_if
//   Addressed read port of the debug snapshot buffer. The read has one cycle of
//   latency: a request on rd_en/rd_addr returns rd_valid/rd_data one cycle later.
//
//   Signals:
//     rd_en     master -> slave  read request
//     rd_addr   master -> slave  buffer index to read
//     rd_valid  slave -> master  read data valid (one cycle after rd_en)
//     rd_data   slave -> master  read data
// -----------------------------------------------------------------------------
interface debug_snapshot_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/debug_snapshot_unit.sv
// -----------------------------------------------------------------------------
// debug_snapshot_unit
//   Debug observation block. Copies NUM_REGS register-file words followed by
//   NUM_MEM data-memory words from the flattened src_data bus into a shadow
//   buffer, in parallel on one Clk edge. Captures happen every cycle (mode 0),
//   once per arm/trigger sequence (mode 1), every DECIM cycles (mode 2) or never
//   (mode 3). The frozen image is read back through an addressed read port.
//
//   Ports:
//     Clk           system clock, rising edge
//     reset         asynchronous active-low reset
//     mode [1:0]    0=continuous, 1=triggered, 2=decimated, 3=hold
//     arm           arm request (mode 1)
//     trig          trigger pulse (mode 1)
//     release_snap  unfreeze after a triggered capture
//     src_data      live words, word i at [i*DATA_W +: DATA_W]
//     rd_if         read port (slave side): rd_en, rd_addr, rd_valid, rd_data
//     state [1:0]   0=IDLE, 1=ARMED, 2=CAPTURED, 3=LIVE
//     snap_count    captures since reset, saturating at 0xFFFF
//     dirty         (SNAPSHOT_DIRTY_TRACK_EN only) per-word changed-since-read
//
//   Optional feature macro: SNAPSHOT_DIRTY_TRACK_EN
// -----------------------------------------------------------------------------
module debug_snapshot_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 20,
    parameter int NUM_MEM  = 2,
    parameter int DECIM    = 8,
    parameter int ADDR_W   = 5
) (
    input  logic                                 Clk,
    input  logic                                 reset,
    input  logic [1:0]                           mode,
    input  logic                                 arm,
    input  logic                                 trig,
    input  logic                                 release_snap,
    input  logic [(NUM_REGS+NUM_MEM)*DATA_W-1:0] src_data,
    debug_snapshot_unit_if.slave                 rd_if,
    output logic [1:0]                           state,
`ifdef SNAPSHOT_DIRTY_TRACK_EN
    output logic [NUM_REGS+NUM_MEM-1:0]          dirty,
`endif
    output logic [15:0]                          snap_count
);

    localparam int NUM_WORDS = NUM_REGS + NUM_MEM;
    localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_TRIG  = 2'd1;
    localparam logic [1:0] MODE_DECIM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CAPTURED = 2'd2,
        ST_LIVE     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic              mode_vld_q;
    logic              mode_chg;
    logic [15:0]       dec_cnt_q, dec_cnt_d;
    logic [15:0]       snap_count_q;
    logic              capture;

    logic [DATA_W-1:0] snap_buf [NUM_WORDS];
    logic [DATA_W-1:0] src_word [NUM_WORDS];
    logic [DATA_W-1:0] rd_word;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // No previous mode exists right after reset, so the first cycle never
    // counts as a mode change.
    assign mode_chg = mode_vld_q && (mode != mode_q);

    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            src_word[i] = src_data[i*DATA_W +: DATA_W];
        end
    end

    // Out-of-range addresses match no word and read back as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_if.rd_addr == ADDR_W'(i)) begin
                rd_word = snap_buf[i];
            end
        end
    end

    // Capture control: next state, capture strobe, decimation counter.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        dec_cnt_d = dec_cnt_q;
        case (mode)
            MODE_CONT: begin
                state_d = ST_LIVE;
                capture = 1'b1;
            end
            MODE_TRIG: begin
                if (mode_chg) begin
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (arm) state_d = ST_ARMED;
                        end
                        ST_ARMED: begin
                            if (trig) begin
                                capture = 1'b1;
                                state_d = ST_CAPTURED;
                            end
                        end
                        ST_CAPTURED: begin
                            // release has priority over a coincident trig
                            if (release_snap) state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            MODE_DECIM: begin
                state_d = ST_LIVE;
                // The counter restarts on a mode change, so it only fires then
                // when the period is a single cycle.
                capture = (dec_cnt_q == DEC_LAST) && (!mode_chg || DECIM == 1);
                dec_cnt_d = (dec_cnt_q == DEC_LAST) ? 16'd0 : dec_cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (mode_chg) dec_cnt_d = 16'd0;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_CONT;
            mode_vld_q   <= 1'b0;
            dec_cnt_q    <= 16'd0;
            snap_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode;
            mode_vld_q <= 1'b1;
            dec_cnt_q  <= dec_cnt_d;
            if (capture && snap_count_q != 16'hFFFF) begin
                snap_count_q <= snap_count_q + 16'd1;
            end
        end
    end

    // Shadow buffer: all words copied in parallel on a capture edge.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                snap_buf[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                snap_buf[i] <= src_word[i];
            end
        end
    end

    // Read port: sampled from the pre-capture buffer, result one cycle later.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_if.rd_en;
            if (rd_if.rd_en) begin
                rd_data_q <= rd_word;
            end
        end
    end

`ifdef SNAPSHOT_DIRTY_TRACK_EN
    logic [NUM_WORDS-1:0] rd_hit;
    logic [NUM_WORDS-1:0] dirty_q;

    always_comb begin
        rd_hit = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            rd_hit[i] = rd_if.rd_en && (rd_if.rd_addr == ADDR_W'(i));
        end
    end

    // A changing capture sets the bit; a read clears it, set wins.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (capture && (src_word[i] != snap_buf[i])) begin
                    dirty_q[i] <= 1'b1;
                end else if (rd_hit[i]) begin
                    dirty_q[i] <= 1'b0;
                end
            end
        end
    end

    assign dirty = dirty_q;
`endif

    assign state          = state_q;
    assign snap_count     = snap_count_q;
    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = rd_data_q;

endmodule
